srm_controller: RTL and testbench

- Instruction register, decoder and control FSM that sequences the Simple RISC Machine `datapath`.
- Latches a 16-bit instruction, decodes its register fields and sign-extended immediates, and steps the datapath's load, select and write strobes through one multi-cycle pass per instruction.
- Sits between the instruction source (memory/top level) and `datapath`, driving every datapath control input directly.

---
 rtl/srm_controller.sv | 135 +++++++++++++
 tb/tb_srm_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/srm_controller.sv
// Simple RISC Machine controller: instruction register, field decode and the
// multi-cycle control FSM that drives every datapath strobe.
module srm_controller #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        load_ir,
   input  logic        s,
   output logic        w,
   output logic        illegal,
   output logic        write,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic        loadc,
   output logic        loads,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] ir;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op, sh;
   logic       is_movi, is_movr, is_alu, is_mvn, is_cmp;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign sximm5 = {{11{ir[4]}}, ir[4:0]};
   assign sximm8 = {{8{ir[7]}}, ir[7:0]};

   assign is_movi = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu  = (opcode == 3'b101);
   assign is_mvn  = is_alu && (op == 2'b11);
   assign is_cmp  = is_alu && (op == 2'b01);

   // IR only accepts new words while idle so an in-flight pass sees stable fields
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         ir    <= IR_RESET;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT && load_ir) ir <= instr;
      end
   end

   always_comb begin
      state_nxt = state;
      w         = 1'b0;
      illegal   = 1'b0;
      write     = 1'b0;
      vsel      = 2'b00;
      loada     = 1'b0;
      loadb     = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      loadc     = 1'b0;
      loads     = 1'b0;
      readnum   = 3'd0;
      writenum  = 3'd0;
      shift     = 2'b00;
      ALUop     = 2'b00;
      case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (is_movi)                state_nxt = S_WRITE_IMM;
            else if (is_movr || is_mvn) state_nxt = S_GET_B;
            else if (is_alu)            state_nxt = S_GET_A;
            else begin
               illegal   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WRITE_IMM: begin
            writenum  = rn;
            vsel      = 2'b10;
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         S_GET_A: begin
            readnum   = rn;
            loada     = 1'b1;
            state_nxt = S_GET_B;
         end
         S_GET_B: begin
            readnum   = rm;
            loadb     = 1'b1;
            state_nxt = S_ALU;
         end
         S_ALU: begin
            shift = sh;
            asel  = is_movr || is_mvn;
            ALUop = is_movr ? 2'b00 : op;
            // CMP only updates flags, so it skips the writeback cycle
            if (is_cmp) begin
               loads     = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               loadc     = 1'b1;
               state_nxt = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            writenum  = rd;
            write     = 1'b1;
            state_nxt = S_WAIT;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_srm_controller.sv
// Directed bench for srm_controller: per-cycle control vectors are queued when an
// instruction is issued and compared as the FSM steps; a small datapath model checks results.
module tb_srm_controller;

   typedef struct packed {
      logic       w, ill, write;
      logic [1:0] vsel;
      logic       la, lb, asel, bsel, lc, ls;
      logic [2:0] rn, wn;
      logic [1:0] sh, op;
   } ctrl_t;

   logic        clk = 1'b0;
   logic        reset, load_ir, s;
   logic [15:0] instr;
   logic        w, illegal, write, loada, loadb, asel, bsel, loadc, loads;
   logic [1:0]  vsel, shift, ALUop;
   logic [2:0]  readnum, writenum;
   logic [15:0] sximm5, sximm8;

   srm_controller #(.IR_RESET(16'h0000)) dut (
      .clk(clk), .reset(reset), .instr(instr), .load_ir(load_ir), .s(s),
      .w(w), .illegal(illegal), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
      .loadc(loadc), .loads(loads), .readnum(readnum), .writenum(writenum),
      .shift(shift), .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   ctrl_t obs;
   assign obs = {w, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads,
                 readnum, writenum, shift, ALUop};

   // behavioural datapath driven by the controller strobes
   logic [15:0] rf [8];
   logic [15:0] ra, rb, rc, bsh, ain, bin, alu_out, wdata;
   logic        zf;
   logic        pl_en = 1'b0;
   logic [2:0]  pl_idx = 3'd0;
   logic [15:0] pl_val = 16'd0;
   int          wr_cnt = 0;

   always_comb begin
      case (shift)
         2'b00:   bsh = rb;
         2'b01:   bsh = {rb[14:0], 1'b0};
         2'b10:   bsh = {1'b0, rb[15:1]};
         default: bsh = {rb[15], rb[15:1]};
      endcase
      ain = asel ? 16'd0 : ra;
      bin = bsel ? sximm5 : bsh;
      case (ALUop)
         2'b00:   alu_out = ain + bin;
         2'b01:   alu_out = ain - bin;
         2'b10:   alu_out = ain & bin;
         default: alu_out = ~bin;
      endcase
      wdata = (vsel == 2'b10) ? sximm8 : rc;
   end

   always @(posedge clk) begin
      if (pl_en) rf[pl_idx] <= pl_val;
      if (write) begin
         rf[writenum] <= wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (loada) ra <= rf[readnum];
      if (loadb) rb <= rf[readnum];
      if (loadc) rc <= alu_out;
      if (loads) zf <= (alu_out == 16'd0);
   end

   int    total = 0;
   int    bad   = 0;
   ctrl_t sb[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic ctrl_t wait_vec();
      ctrl_t v = '0;
      v.w = 1'b1;
      return v;
   endfunction

   // expected control vectors from DECODE through the return to WAIT
   task automatic push_seq(input logic [15:0] ins);
      ctrl_t v;
      logic [2:0] opc = ins[15:13];
      logic [1:0] op  = ins[12:11];
      logic movi = (opc == 3'b110) && (op == 2'b10);
      logic movr = (opc == 3'b110) && (op == 2'b00);
      logic alu  = (opc == 3'b101);
      logic cmp  = alu && (op == 2'b01);
      logic mvn  = alu && (op == 2'b11);
      v = '0;
      v.ill = !(movi || movr || alu);
      sb.push_back(v);
      if (movi) begin
         v = '0; v.wn = ins[10:8]; v.vsel = 2'b10; v.write = 1'b1;
         sb.push_back(v);
      end else if (movr || alu) begin
         if (!movr && !mvn) begin
            v = '0; v.rn = ins[10:8]; v.la = 1'b1;
            sb.push_back(v);
         end
         v = '0; v.rn = ins[2:0]; v.lb = 1'b1;
         sb.push_back(v);
         v = '0; v.sh = ins[4:3]; v.asel = movr || mvn;
         v.op = movr ? 2'b00 : op;
         v.ls = cmp; v.lc = !cmp;
         sb.push_back(v);
         if (!cmp) begin
            v = '0; v.wn = ins[7:5]; v.write = 1'b1;
            sb.push_back(v);
         end
      end
      sb.push_back(wait_vec());
   endtask

   task automatic exec(input logic [15:0] ins, input int ld_at, input int rst_at,
                       input string tag);
      ctrl_t e;
      int i = 0;
      instr = ins; load_ir = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      s = 1'b0; load_ir = 1'b0;
      push_seq(ins);
      while (sb.size() > 0 && i < 20) begin
         e = sb.pop_front();
         chk($sformatf("%s_step%0d", tag, i), 32'(obs), 32'(e));
         if (sb.size() == 0) break;
         if (i == ld_at) begin instr = 16'hE000; load_ir = 1'b1; end
         if (i == rst_at) reset = 1'b1;
         @(posedge clk); #1;
         load_ir = 1'b0;
         if (reset) begin
            reset = 1'b0;
            sb.delete();
            sb.push_back(wait_vec());
         end
         i++;
      end
      if (i >= 20) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic preload(input logic [2:0] idx, input logic [15:0] val);
      pl_idx = idx; pl_val = val; pl_en = 1'b1;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   int wr_before;

   initial begin
      reset = 1'b1; load_ir = 1'b0; s = 1'b0; instr = 16'h0000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_ctrl", 32'(obs), 32'(wait_vec()));
      chk("reset_sximm8", 32'(sximm8), 32'h0000);

      preload(3'd5, 16'd42);
      preload(3'd3, 16'd13);
      preload(3'd1, 16'd9);
      preload(3'd2, 16'd9);

      // CMP R1,R2 with equal operands sets Z
      exec(16'hA902, -1, -1, "cmp");
      chk("cmp_z", 32'(zf), 32'd1);

      // MOV R4,#-1
      exec(16'hD4FF, -1, -1, "movi");
      chk("movi_sximm8", 32'(sximm8), 32'hFFFF);
      chk("movi_r4", 32'(rf[4]), 32'hFFFF);

      // ADD R2,R5,R3 with a load_ir attempt during GET_A that must be ignored
      exec(16'hA543, 1, -1, "add");
      chk("add_r2", 32'(rf[2]), 32'd55);
      chk("add_ir_kept", 32'(sximm5), 32'h0003);

      // MOV R7,R3,LSL#1
      exec(16'hC0EB, -1, -1, "movr");
      chk("movr_r7", 32'(rf[7]), 32'd26);

      // AND R6,R5,R3 and MVN R0,R3
      exec(16'hB5C3, -1, -1, "and");
      chk("and_r6", 32'(rf[6]), 32'd8);
      exec(16'hB803, -1, -1, "mvn");
      chk("mvn_r0", 32'(rf[0]), 32'hFFF2);

      // unsupported opcode: single-cycle illegal pulse, no strobes
      exec(16'hE000, -1, -1, "illegal");
      chk("illegal_gone", 32'(illegal), 32'd0);

      // reset while in GET_B aborts ADD before any write
      wr_before = wr_cnt;
      exec(16'hA543, -1, 2, "rst_getb");
      @(posedge clk); #1;
      chk("rst_no_write", 32'(wr_cnt), 32'(wr_before));
      chk("rst_ir", 32'(sximm8), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
